// File: rtl/rollback_ctrl_pkg.sv
// Shared types and width constants for the rollback sequencer.
// Optional build macro: ROLLBACK_PERF_EN (adds saturating perf counters to the top).
package rollback_ctrl_pkg;

    localparam int NUM_ROB   = 32;
    localparam int NUM_FL    = 32;
    localparam int NUM_LSQ   = 8;
    localparam int ROB_IDX_W = $clog2(NUM_ROB);
    localparam int FL_IDX_W  = $clog2(NUM_FL);
    localparam int LSQ_IDX_W = $clog2(NUM_LSQ);
    localparam int PC_W      = 64;

    typedef enum logic [1:0] {
        RB_IDLE   = 2'd0,
        RB_FLUSH  = 2'd1,
        RB_REFILL = 2'd2
    } RB_STATE_t;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [FL_IDX_W-1:0]  fl_idx;
        logic [LSQ_IDX_W-1:0] sq_idx;
        logic [LSQ_IDX_W-1:0] lq_idx;
        logic [PC_W-1:0]      target_pc;
    } rollback_req_t;

    // Age of a ROB entry relative to the head; wraps modulo the ROB size.
    function automatic logic [ROB_IDX_W-1:0] rob_age(input logic [ROB_IDX_W-1:0] idx,
                                                     input logic [ROB_IDX_W-1:0] head);
        return idx - head;
    endfunction

endpackage

// File: rtl/rollback_oldest_sel.sv
// Oldest-request selector: pairwise reduction tree over the requesters.
// Ties resolve to the lower requester index (left child wins on equal age).
module rollback_oldest_sel #(
    parameter int NUM_REQ = 4,
    parameter int ROB_W   = 5,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*ROB_W-1:0] req_rob_idx,
    input  logic [ROB_W-1:0]         rob_head_idx,
    output logic [IDX_W-1:0]         win_idx,
    output logic [ROB_W-1:0]         win_dist,
    output logic                     any_valid
);

    localparam int LVLS   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LEAVES = 1 << LVLS;

    logic             node_v [LEAVES];
    logic [ROB_W-1:0] node_d [LEAVES];
    logic [IDX_W-1:0] node_i [LEAVES];
    logic             take_r;

    // Fill leaves with per-request age, then reduce level by level in place.
    always_comb begin
        take_r = 1'b0;
        for (int i = 0; i < LEAVES; i++) begin
            node_v[i] = 1'b0;
            node_d[i] = '0;
            node_i[i] = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            node_v[i] = req_valid[i];
            node_d[i] = req_rob_idx[i*ROB_W +: ROB_W] - rob_head_idx;
            node_i[i] = IDX_W'(i);
        end
        for (int l = 1; l <= LVLS; l++) begin
            for (int k = 0; k < (LEAVES >> l); k++) begin
                take_r = node_v[2*k+1] &&
                         (!node_v[2*k] || (node_d[2*k+1] < node_d[2*k]));
                if (take_r) begin
                    node_v[k] = node_v[2*k+1];
                    node_d[k] = node_d[2*k+1];
                    node_i[k] = node_i[2*k+1];
                end else begin
                    node_v[k] = node_v[2*k];
                    node_d[k] = node_d[2*k];
                    node_i[k] = node_i[2*k];
                end
            end
        end
    end

    assign win_idx   = node_i[0];
    assign win_dist  = node_d[0];
    assign any_valid = node_v[0];

endmodule

// File: rtl/rollback_ctrl.sv
// Rollback sequencer: picks the oldest rollback request, pulses rollback/redirect
// for one cycle, then stalls fetch for STALL_CYCLES. Strictly older requests
// arriving mid-recovery preempt; anything else during recovery is dropped.
// Optional build macro: ROLLBACK_PERF_EN adds perf_rollback_cnt/perf_preempt_cnt/perf_drop_cnt.
// Handshake: req_valid is a one-cycle qualifier with no ready; consumers must
// qualify the rollback index/pc outputs with rollback_en.
module rollback_ctrl
    import rollback_ctrl_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ROB_W        = ROB_IDX_W,
    parameter int FL_W         = FL_IDX_W,
    parameter int LSQ_W        = LSQ_IDX_W,
    parameter int STALL_CYCLES = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*ROB_W-1:0] req_rob_idx,
    input  logic [NUM_REQ*FL_W-1:0]  req_fl_idx,
    input  logic [NUM_REQ*LSQ_W-1:0] req_sq_idx,
    input  logic [NUM_REQ*LSQ_W-1:0] req_lq_idx,
    input  logic [NUM_REQ*64-1:0]    req_target_pc,
    input  logic [ROB_W-1:0]         rob_head_idx,
    output logic                     rollback_en,
    output logic [ROB_W-1:0]         rob_rollback_idx,
    output logic [FL_W-1:0]          fl_rollback_idx,
    output logic [LSQ_W-1:0]         sq_rollback_idx,
    output logic [LSQ_W-1:0]         lq_rollback_idx,
    output logic                     redirect_valid,
    output logic [63:0]              redirect_pc,
    output logic                     fetch_stall,
    output logic                     busy,
    output logic [1:0]               state_dbg
`ifdef ROLLBACK_PERF_EN
    ,
    output logic [31:0]              perf_rollback_cnt,
    output logic [31:0]              perf_preempt_cnt,
    output logic [31:0]              perf_drop_cnt
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;

    localparam logic [1:0] ST_IDLE   = RB_IDLE;
    localparam logic [1:0] ST_FLUSH  = RB_FLUSH;
    localparam logic [1:0] ST_REFILL = RB_REFILL;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rollback_req_t    lat_q, lat_d;
    rollback_req_t    win_req;
    logic [IDX_W-1:0] win_idx;
    logic [ROB_W-1:0] win_dist;
    logic [ROB_W-1:0] lat_dist;
    logic             any_valid;
    logic             preempt;

    rollback_oldest_sel #(
        .NUM_REQ (NUM_REQ),
        .ROB_W   (ROB_W),
        .IDX_W   (IDX_W)
    ) u_sel (
        .req_valid    (req_valid),
        .req_rob_idx  (req_rob_idx),
        .rob_head_idx (rob_head_idx),
        .win_idx      (win_idx),
        .win_dist     (win_dist),
        .any_valid    (any_valid)
    );

    // Gather the winning requester's restore fields.
    always_comb begin
        win_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == win_idx) begin
                win_req.valid     = req_valid[i];
                win_req.rob_idx   = req_rob_idx[i*ROB_W +: ROB_W];
                win_req.fl_idx    = req_fl_idx[i*FL_W +: FL_W];
                win_req.sq_idx    = req_sq_idx[i*LSQ_W +: LSQ_W];
                win_req.lq_idx    = req_lq_idx[i*LSQ_W +: LSQ_W];
                win_req.target_pc = req_target_pc[i*64 +: 64];
            end
        end
    end

    // Recovery FSM; the latched age is recomputed every cycle against the live head.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lat_d    = lat_q;
        lat_dist = rob_age(lat_q.rob_idx, rob_head_idx);
        preempt  = (state_q != ST_IDLE) && lat_q.valid && any_valid && (win_dist < lat_dist);
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    state_d = ST_FLUSH;
                    lat_d   = win_req;
                end
            end
            ST_FLUSH: begin
                if (preempt) begin
                    state_d = ST_FLUSH;
                    lat_d   = win_req;
                end else if (STALL_CYCLES > 0) begin
                    state_d = ST_REFILL;
                    cnt_d   = CNT_W'(STALL_CYCLES);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REFILL: begin
                if (preempt) begin
                    state_d = ST_FLUSH;
                    lat_d   = win_req;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, stall counter and latched winner registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
        end
    end

    assign rollback_en      = (state_q == ST_FLUSH);
    assign redirect_valid   = rollback_en;
    assign fetch_stall      = (state_q != ST_IDLE);
    assign busy             = (state_q != ST_IDLE);
    assign state_dbg        = state_q;
    assign rob_rollback_idx = lat_q.rob_idx;
    assign fl_rollback_idx  = lat_q.fl_idx;
    assign sq_rollback_idx  = lat_q.sq_idx;
    assign lq_rollback_idx  = lat_q.lq_idx;
    assign redirect_pc      = lat_q.target_pc;

`ifdef ROLLBACK_PERF_EN
    logic [31:0] perf_rb_q, perf_rb_d;
    logic [31:0] perf_pre_q, perf_pre_d;
    logic [31:0] perf_drop_q, perf_drop_d;
    logic        drop;

    // Saturating event counters.
    always_comb begin
        drop        = (state_q != ST_IDLE) && any_valid && !preempt;
        perf_rb_d   = perf_rb_q;
        perf_pre_d  = perf_pre_q;
        perf_drop_d = perf_drop_q;
        if (rollback_en && (perf_rb_q != 32'hFFFF_FFFF)) perf_rb_d = perf_rb_q + 32'd1;
        if (preempt && (perf_pre_q != 32'hFFFF_FFFF)) perf_pre_d = perf_pre_q + 32'd1;
        if (drop && (perf_drop_q != 32'hFFFF_FFFF)) perf_drop_d = perf_drop_q + 32'd1;
    end

    // Perf counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_rb_q   <= '0;
            perf_pre_q  <= '0;
            perf_drop_q <= '0;
        end else begin
            perf_rb_q   <= perf_rb_d;
            perf_pre_q  <= perf_pre_d;
            perf_drop_q <= perf_drop_d;
        end
    end

    assign perf_rollback_cnt = perf_rb_q;
    assign perf_preempt_cnt  = perf_pre_q;
    assign perf_drop_cnt     = perf_drop_q;
`endif

endmodule

// File: tb/tb_rollback_ctrl.sv
// Directed bench for rollback_ctrl: instance a (STALL_CYCLES=2), instance b (STALL_CYCLES=0).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_rollback_ctrl;

    logic          clock;
    logic          reset;
    logic [3:0]    req_valid;
    logic [19:0]   req_rob_idx;
    logic [19:0]   req_fl_idx;
    logic [11:0]   req_sq_idx;
    logic [11:0]   req_lq_idx;
    logic [255:0]  req_target_pc;
    logic [4:0]    rob_head_idx;

    logic          a_en, a_rv, a_stall, a_busy;
    logic [4:0]    a_rob, a_fl;
    logic [2:0]    a_sq, a_lq;
    logic [63:0]   a_pc;
    logic [1:0]    a_state;
    logic          b_en, b_rv, b_stall, b_busy;
    logic [4:0]    b_rob, b_fl;
    logic [2:0]    b_sq, b_lq;
    logic [63:0]   b_pc;
    logic [1:0]    b_state;
`ifdef ROLLBACK_PERF_EN
    logic [31:0]   a_perf_rb, a_perf_pre, a_perf_drop;
    logic [31:0]   b_perf_rb, b_perf_pre, b_perf_drop;
`endif

    int checks;
    int failures;

    rollback_ctrl u_dut_a (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_rob_idx      (req_rob_idx),
        .req_fl_idx       (req_fl_idx),
        .req_sq_idx       (req_sq_idx),
        .req_lq_idx       (req_lq_idx),
        .req_target_pc    (req_target_pc),
        .rob_head_idx     (rob_head_idx),
        .rollback_en      (a_en),
        .rob_rollback_idx (a_rob),
        .fl_rollback_idx  (a_fl),
        .sq_rollback_idx  (a_sq),
        .lq_rollback_idx  (a_lq),
        .redirect_valid   (a_rv),
        .redirect_pc      (a_pc),
        .fetch_stall      (a_stall),
        .busy             (a_busy),
        .state_dbg        (a_state)
`ifdef ROLLBACK_PERF_EN
        ,
        .perf_rollback_cnt (a_perf_rb),
        .perf_preempt_cnt  (a_perf_pre),
        .perf_drop_cnt     (a_perf_drop)
`endif
    );

    rollback_ctrl #(.STALL_CYCLES(0)) u_dut_b (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_rob_idx      (req_rob_idx),
        .req_fl_idx       (req_fl_idx),
        .req_sq_idx       (req_sq_idx),
        .req_lq_idx       (req_lq_idx),
        .req_target_pc    (req_target_pc),
        .rob_head_idx     (rob_head_idx),
        .rollback_en      (b_en),
        .rob_rollback_idx (b_rob),
        .fl_rollback_idx  (b_fl),
        .sq_rollback_idx  (b_sq),
        .lq_rollback_idx  (b_lq),
        .redirect_valid   (b_rv),
        .redirect_pc      (b_pc),
        .fetch_stall      (b_stall),
        .busy             (b_busy),
        .state_dbg        (b_state)
`ifdef ROLLBACK_PERF_EN
        ,
        .perf_rollback_cnt (b_perf_rb),
        .perf_preempt_cnt  (b_perf_pre),
        .perf_drop_cnt     (b_perf_drop)
`endif
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive_req(input int i, input logic [4:0] rob, input logic [4:0] fl,
                             input logic [2:0] sq, input logic [2:0] lq, input logic [63:0] pc);
        req_valid[i]            = 1'b1;
        req_rob_idx[i*5 +: 5]   = rob;
        req_fl_idx[i*5 +: 5]    = fl;
        req_sq_idx[i*3 +: 3]    = sq;
        req_lq_idx[i*3 +: 3]    = lq;
        req_target_pc[i*64 +: 64] = pc;
    endtask

    task automatic clear_reqs();
        req_valid     = '0;
        req_rob_idx   = '0;
        req_fl_idx    = '0;
        req_sq_idx    = '0;
        req_lq_idx    = '0;
        req_target_pc = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_reqs();
        rob_head_idx = '0;
        repeat (2) @(negedge clock);
        checks++; if (a_en !== 1'b0) begin failures++; $display("FAIL reset_en actual=%0h expected=0", a_en); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%0h expected=0", a_busy); end
        checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL reset_stall actual=%0h expected=0", a_stall); end
        checks++; if (a_rob !== 5'd0) begin failures++; $display("FAIL reset_rob actual=%0h expected=0", a_rob); end
        checks++; if (a_pc !== 64'd0) begin failures++; $display("FAIL reset_pc actual=%0h expected=0", a_pc); end
        checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL reset_b_busy actual=%0h expected=0", b_busy); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        rob_head_idx = 5'd0;
        drive_req(0, 5'd7, 5'd1, 3'd1, 3'd1, 64'h1000);
        drive_req(2, 5'd3, 5'd9, 3'd2, 3'd5, 64'h2000);
        @(negedge clock);
        clear_reqs();
        checks++; if (a_en !== 1'b1) begin failures++; $display("FAIL basic_en actual=%0h expected=1", a_en); end
        checks++; if (a_rv !== 1'b1) begin failures++; $display("FAIL basic_redirect_valid actual=%0h expected=1", a_rv); end
        checks++; if (a_rob !== 5'd3) begin failures++; $display("FAIL basic_rob actual=%0h expected=3", a_rob); end
        checks++; if (a_fl !== 5'd9) begin failures++; $display("FAIL basic_fl actual=%0h expected=9", a_fl); end
        checks++; if ({a_sq, a_lq} !== {3'd2, 3'd5}) begin failures++; $display("FAIL basic_sq_lq actual=%0h/%0h expected=2/5", a_sq, a_lq); end
        checks++; if (a_pc !== 64'h2000) begin failures++; $display("FAIL basic_pc actual=%0h expected=2000", a_pc); end
        checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL basic_stall_flush actual=%0h expected=1", a_stall); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            checks++; if ({a_en, a_stall} !== 2'b01) begin failures++; $display("FAIL basic_refill%0d en_stall actual=%0b expected=01", c, {a_en, a_stall}); end
        end
        @(negedge clock);
        checks++; if ({a_stall, a_busy} !== 2'b00) begin failures++; $display("FAIL basic_idle stall_busy actual=%0b expected=00", {a_stall, a_busy}); end
    endtask

    task automatic test_wrap();
        rob_head_idx = 5'd30;
        drive_req(1, 5'd2, 5'd4, 3'd1, 3'd1, 64'h1111);
        drive_req(3, 5'd31, 5'd7, 3'd6, 3'd2, 64'h3333);
        @(negedge clock);
        clear_reqs();
        checks++; if (a_en !== 1'b1) begin failures++; $display("FAIL wrap_en actual=%0h expected=1", a_en); end
        checks++; if (a_rob !== 5'd31) begin failures++; $display("FAIL wrap_rob actual=%0h expected=1f", a_rob); end
        checks++; if (a_pc !== 64'h3333) begin failures++; $display("FAIL wrap_pc actual=%0h expected=3333", a_pc); end
        repeat (3) @(negedge clock);
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL wrap_idle actual=%0h expected=0", a_busy); end
    endtask

    // Issued in the first IDLE cycle after REFILL; also exercises the age tie.
    task automatic test_back_to_back_tie();
        rob_head_idx = 5'd0;
        drive_req(0, 5'd5, 5'd11, 3'd3, 3'd4, 64'h5000);
        drive_req(1, 5'd5, 5'd12, 3'd6, 3'd7, 64'h6000);
        @(negedge clock);
        clear_reqs();
        checks++; if (a_en !== 1'b1) begin failures++; $display("FAIL tie_en actual=%0h expected=1", a_en); end
        checks++; if (a_fl !== 5'd11) begin failures++; $display("FAIL tie_fl actual=%0h expected=b", a_fl); end
        checks++; if ({a_sq, a_lq} !== {3'd3, 3'd4}) begin failures++; $display("FAIL tie_sq_lq actual=%0h/%0h expected=3/4", a_sq, a_lq); end
        checks++; if (a_pc !== 64'h5000) begin failures++; $display("FAIL tie_pc actual=%0h expected=5000", a_pc); end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_preempt();
        rob_head_idx = 5'd0;
        drive_req(0, 5'd10, 5'd1, 3'd1, 3'd1, 64'hA000);
        @(negedge clock);
        clear_reqs();
        checks++; if (a_rob !== 5'd10) begin failures++; $display("FAIL preempt_first_rob actual=%0h expected=a", a_rob); end
        @(negedge clock);
        checks++; if (a_state !== 2'd2) begin failures++; $display("FAIL preempt_refill_state actual=%0h expected=2", a_state); end
        drive_req(1, 5'd6, 5'd2, 3'd2, 3'd2, 64'h6060);
        @(negedge clock);
        clear_reqs();
        checks++; if (a_en !== 1'b1) begin failures++; $display("FAIL preempt_en actual=%0h expected=1", a_en); end
        checks++; if (a_rob !== 5'd6) begin failures++; $display("FAIL preempt_rob actual=%0h expected=6", a_rob); end
        checks++; if (a_pc !== 64'h6060) begin failures++; $display("FAIL preempt_pc actual=%0h expected=6060", a_pc); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            checks++; if ({a_en, a_stall} !== 2'b01) begin failures++; $display("FAIL preempt_restall%0d actual=%0b expected=01", c, {a_en, a_stall}); end
        end
        @(negedge clock);
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL preempt_idle actual=%0h expected=0", a_busy); end
    endtask

    task automatic test_drop();
        rob_head_idx = 5'd0;
        drive_req(0, 5'd10, 5'd3, 3'd1, 3'd1, 64'hB000);
        @(negedge clock);
        clear_reqs();
        @(negedge clock);
        drive_req(2, 5'd12, 5'd5, 3'd5, 3'd5, 64'hC000);
        drive_req(3, 5'd10, 5'd6, 3'd6, 3'd6, 64'hC100);
        @(negedge clock);
        clear_reqs();
        checks++; if (a_en !== 1'b0) begin failures++; $display("FAIL drop_en actual=%0h expected=0", a_en); end
        checks++; if (a_rob !== 5'd10) begin failures++; $display("FAIL drop_rob actual=%0h expected=a", a_rob); end
        checks++; if (a_pc !== 64'hB000) begin failures++; $display("FAIL drop_pc actual=%0h expected=b000", a_pc); end
        checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL drop_stall actual=%0h expected=1", a_stall); end
        @(negedge clock);
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL drop_idle actual=%0h expected=0", a_busy); end
    endtask

    task automatic test_preempt_flush();
        rob_head_idx = 5'd0;
        drive_req(0, 5'd20, 5'd1, 3'd1, 3'd1, 64'hD000);
        @(negedge clock);
        clear_reqs();
        checks++; if ({a_en, a_rob} !== {1'b1, 5'd20}) begin failures++; $display("FAIL pflush_first actual=%0h expected=34", {a_en, a_rob}); end
        drive_req(1, 5'd8, 5'd2, 3'd2, 3'd2, 64'hE000);
        @(negedge clock);
        clear_reqs();
        checks++; if (a_en !== 1'b1) begin failures++; $display("FAIL pflush_second_en actual=%0h expected=1", a_en); end
        checks++; if (a_pc !== 64'hE000) begin failures++; $display("FAIL pflush_pc actual=%0h expected=e000", a_pc); end
        @(negedge clock);
        checks++; if ({a_en, a_stall} !== 2'b01) begin failures++; $display("FAIL pflush_refill actual=%0b expected=01", {a_en, a_stall}); end
        repeat (2) @(negedge clock);
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL pflush_idle actual=%0h expected=0", a_busy); end
    endtask

    task automatic test_stall_zero();
        rob_head_idx = 5'd0;
        drive_req(2, 5'd4, 5'd8, 3'd3, 3'd3, 64'hF000);
        @(negedge clock);
        clear_reqs();
        checks++; if ({b_en, b_busy, b_stall} !== 3'b111) begin failures++; $display("FAIL stall0_pulse actual=%0b expected=111", {b_en, b_busy, b_stall}); end
        checks++; if (b_pc !== 64'hF000) begin failures++; $display("FAIL stall0_pc actual=%0h expected=f000", b_pc); end
        @(negedge clock);
        checks++; if ({b_en, b_busy, b_stall} !== 3'b000) begin failures++; $display("FAIL stall0_after actual=%0b expected=000", {b_en, b_busy, b_stall}); end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset_mid();
        rob_head_idx = 5'd0;
        drive_req(0, 5'd9, 5'd9, 3'd4, 3'd4, 64'h9000);
        @(negedge clock);
        clear_reqs();
        checks++; if (a_en !== 1'b1) begin failures++; $display("FAIL rstmid_pulse actual=%0h expected=1", a_en); end
        @(negedge clock);
        checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL rstmid_refill actual=%0h expected=1", a_stall); end
        reset = 1'b0;
        #1;
        checks++; if ({a_en, a_rv, a_stall, a_busy} !== 4'b0000) begin failures++; $display("FAIL rstmid_ctrl actual=%0b expected=0000", {a_en, a_rv, a_stall, a_busy}); end
        checks++; if ({a_rob, a_fl, a_sq, a_lq} !== 16'd0) begin failures++; $display("FAIL rstmid_fields actual=%0h expected=0", {a_rob, a_fl, a_sq, a_lq}); end
        checks++; if (a_pc !== 64'd0) begin failures++; $display("FAIL rstmid_pc actual=%0h expected=0", a_pc); end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++; if ({a_en, a_busy} !== 2'b00) begin failures++; $display("FAIL rstmid_nopulse%0d actual=%0b expected=00", c, {a_en, a_busy}); end
        end
`ifdef ROLLBACK_PERF_EN
        checks++; if ({a_perf_rb, a_perf_pre, a_perf_drop} !== 96'd0) begin failures++; $display("FAIL rstmid_perf actual=%0h/%0h/%0h expected=0/0/0", a_perf_rb, a_perf_pre, a_perf_drop); end
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back_tie();
        test_preempt();
        test_drop();
        test_preempt_flush();
        test_stall_zero();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rollback_ctrl.md
Name: rollback_ctrl

Overview:
Central recovery sequencer for the out-of-order core. It collects rollback requests from branch FUs and load-violation sources and selects the oldest relative to the ROB head. It then drives a single-cycle rollback pulse to ROB/FL/SQ/LQ, redirects fetch, and holds fetch stalled for a fixed refill window. Requests arriving mid-recovery either preempt the active recovery (if strictly older) or are dropped.

Parameters:
NUM_REQ, 4, number of rollback requesters (2 branch + 2 load-violation in the default build)
ROB_W, 5, ROB index width (log2 NUM_ROB)
FL_W, 5, free-list index width
LSQ_W, 3, SQ/LQ index width
STALL_CYCLES, 2, fetch-stall cycles after the rollback pulse; 0 is legal

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester rollback request, one-cycle qualified
req_rob_idx  in  NUM_REQ*ROB_W  ROB index of the requesting instruction
req_fl_idx  in  NUM_REQ*FL_W  free-list restore point
req_sq_idx  in  NUM_REQ*LSQ_W  SQ restore point
req_lq_idx  in  NUM_REQ*LSQ_W  LQ restore point
req_target_pc  in  NUM_REQ*64  correct fetch PC
rob_head_idx  in  ROB_W  current ROB head, the age reference
rollback_en  out  1  one-cycle rollback pulse
rob_rollback_idx  out  ROB_W  registered winner field
fl_rollback_idx  out  FL_W  registered winner field
sq_rollback_idx  out  LSQ_W  registered winner field
lq_rollback_idx  out  LSQ_W  registered winner field
redirect_valid  out  1  equals rollback_en
redirect_pc  out  64  fetch target for the redirect
fetch_stall  out  1  fetch must not issue new instructions
busy  out  1  state != IDLE

Behaviour:
- Age: dist = (req_rob_idx - rob_head_idx) mod 2^ROB_W. Smaller dist = older. Ties go to the lower requester index.
- Winner: the oldest valid request in a cycle, chosen combinationally and latched at the clock edge.
- States:
  - IDLE: on any req_valid, latch the winner and go to FLUSH.
  - FLUSH: lasts exactly one cycle. rollback_en=redirect_valid=1 with latched fields; fetch_stall=1. Next state is REFILL if STALL_CYCLES>0, else IDLE.
  - REFILL: fetch_stall=1. The counter loads STALL_CYCLES on entry and decrements each cycle; go to IDLE when it reaches 1.
- Latency: a request in cycle N produces the rollback_en pulse in cycle N+1.
- Mid-recovery requests (in FLUSH or REFILL), evaluated every cycle:
  - If the winner dist is strictly less than the latched dist, relatch and go to FLUSH next cycle. This issues a new pulse and restarts the stall count.
  - Equal or greater dist means the request is dropped silently.
- Back-to-back: in the IDLE cycle directly after REFILL, new requests are accepted normally.
- rollback_en is never high on two consecutive cycles unless a preempt occurs in the FLUSH cycle.
- Output fields hold their latched values outside the pulse; consumers must qualify them with rollback_en.
- Reset: async assert forces IDLE; all outputs go to 0, counter to 0, latched fields to 0. Release is synchronous to clock. A reset asserted mid-recovery abandons the recovery and produces no pulse.
- rob_head_idx is sampled every cycle and not latched; the latched dist is recomputed each cycle from the latched rob_idx.

Optional Feature:
ROLLBACK_PERF_EN
- Defined: adds three 32-bit saturating output counters, reset to 0:
  - perf_rollback_cnt: incremented on every rollback_en pulse.
  - perf_preempt_cnt: incremented on every preemption.
  - perf_drop_cnt: incremented once per cycle in which at least one valid request is dropped.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - rollback_req_t struct {valid, rob_idx, fl_idx, sq_idx, lq_idx, target_pc}.
  - RB_STATE_t enum {RB_IDLE, RB_FLUSH, RB_REFILL}.
  - Width constants derived from NUM_ROB/NUM_FL/NUM_LSQ.
- Sub-module rollback_oldest_sel: combinational log-depth tree over NUM_REQ requests. Outputs winner index, winner dist and any_valid. Instantiated once.

Test Plan:
1. head=0; req0 valid rob=7, req2 valid rob=3 in cycle N -> cycle N+1: rollback_en=1, rob_rollback_idx=3, redirect_pc=req2 pc. Then fetch_stall=1 for 3 cycles total (FLUSH + 2 REFILL), then IDLE.
2. Wrap: head=30; req1 rob=2 (dist 4), req3 rob=31 (dist 1) -> winner rob=31.
3. Tie: req0 and req1 both rob=5 -> winner req0 fields.
4. Preempt: active rob=10 in REFILL cycle 1; req rob=6 with head=0 -> next cycle second pulse with rob=6, stall restarts at 2. A req rob=12 instead is dropped and the FSM returns to IDLE on schedule.
5. STALL_CYCLES=0: single req -> one-cycle pulse, busy deasserted the following cycle.
6. Reset asserted mid-REFILL -> all outputs 0 immediately and no further pulse. With ROLLBACK_PERF_EN: counters read 0 after release.
